// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants, init timing and the message ROM
// for the lcd_mensajes display stage.
package lcd_pkg;

  typedef enum logic [2:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_ADDR, S_CHARS} lcd_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_EHI, TX_HOLD, TX_WAIT} tx_phase_e;

  typedef struct packed {
    logic [3:0]  nib;
    logic        rs;
    logic [13:0] wait_us;
  } nib_req_t;

  localparam logic [7:0] CMD_FUNC  = 8'h28;
  localparam logic [7:0] CMD_DISP  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;

  localparam logic [13:0] PWR_WAIT_US   = 14'd15000;
  localparam logic [13:0] INIT_WAIT0_US = 14'd4100;
  localparam logic [13:0] INIT_WAIT1_US = 14'd100;
  localparam logic [13:0] INIT_WAIT3_US = 14'd40;
  localparam logic [13:0] CMD_WAIT_US   = 14'd40;
  localparam logic [13:0] CLEAR_WAIT_US = 14'd1640;
  localparam logic [13:0] NIB_GAP_US    = 14'd1;

  localparam int INIT_STEPS = 12;

  // Steps 0..3 are the bare 8-bit-mode wake-up nibbles; 4..11 are byte halves.
  function automatic nib_req_t init_step(input logic [3:0] s);
    nib_req_t    r;
    logic [7:0]  cmd;
    logic [13:0] w;
    r   = '0;
    cmd = CMD_FUNC;
    w   = CMD_WAIT_US;
    case (s[3:1])
      3'd3: cmd = CMD_DISP;
      3'd4: cmd = CMD_ENTRY;
      3'd5: begin cmd = CMD_CLEAR; w = CLEAR_WAIT_US; end
      default: ;
    endcase
    r.nib     = s[0] ? cmd[3:0] : cmd[7:4];
    r.wait_us = s[0] ? w : NIB_GAP_US;
    case (s)
      4'd0:       begin r.nib = 4'h3; r.wait_us = INIT_WAIT0_US; end
      4'd1, 4'd2: begin r.nib = 4'h3; r.wait_us = INIT_WAIT1_US; end
      4'd3:       begin r.nib = 4'h2; r.wait_us = INIT_WAIT3_US; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] msg_char(input logic [3:0] c, input logic [7:0] idx);
    logic [127:0] s;
    case (c)
      4'h0:    s = "BIENVENIDO      ";
      4'h1:    s = "SELECCIONE      ";
      4'h2:    s = "PRODUCTO 1      ";
      4'h3:    s = "PRODUCTO 2      ";
      4'h4:    s = "PRODUCTO 3      ";
      4'h5:    s = "INSERTE MONEDAS ";
      4'h6:    s = "PROCESANDO      ";
      4'h7:    s = "ENTREGANDO      ";
      4'h8:    s = "GRACIAS         ";
      4'h9:    s = "ERROR           ";
      default: s = {16{8'h20}};
    endcase
    return (idx < 8'd16) ? s[{~idx[3:0], 3'b000} +: 8] : 8'h20;
  endfunction

endpackage

// File: rtl/lcd_mensajes_nibble_tx.sv
// One 4-bit LCD transfer: setup cycle, E strobe, hold, then a microsecond wait.
// Out of reset it sits in the power-up wait so no extra cycle is lost.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int US_CYC = 50,
  parameter int E_CYC  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  nib,
  input  logic        rs,
  input  logic [13:0] wait_us,
  output logic [3:0]  lcd_d,
  output logic        lcd_rs,
  output logic        lcd_e,
  output logic        done
);

  localparam int CNT_MAX = int'(PWR_WAIT_US) * US_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_phase_e        ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [13:0]      wait_q, wait_d;
  logic [3:0]       d_q, d_d;
  logic             rs_q, rs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q   <= TX_WAIT;
      cnt_q  <= CNT_W'(CNT_MAX - 1);
      wait_q <= '0;
      d_q    <= '0;
      rs_q   <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      d_q    <= d_d;
      rs_q   <= rs_d;
    end
  end

  // done is high on the last wait cycle so the next start follows back-to-back
  assign done   = (ph_q == TX_WAIT) && (cnt_q == '0);
  assign lcd_e  = (ph_q == TX_EHI);
  assign lcd_d  = d_q;
  assign lcd_rs = rs_q;

  always_comb begin
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    wait_d = wait_q;
    d_d    = d_q;
    rs_d   = rs_q;
    case (ph_q)
      TX_SETUP: begin
        ph_d  = TX_EHI;
        cnt_d = CNT_W'(E_CYC - 1);
      end
      TX_EHI: begin
        if (cnt_q == '0) begin
          ph_d  = TX_HOLD;
          cnt_d = CNT_W'(E_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      TX_HOLD: begin
        if (cnt_q == '0) begin
          ph_d  = TX_WAIT;
          cnt_d = CNT_W'(int'(wait_q) * US_CYC - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      TX_WAIT: begin
        if (cnt_q == '0) ph_d = TX_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
    if (start) begin
      ph_d   = TX_SETUP;
      d_d    = nib;
      rs_d   = rs;
      wait_d = wait_us;
    end
  end

endmodule

// File: rtl/lcd_mensajes.sv
// HD44780 4-bit driver: power-up init, then rewrites line 1 whenever code changes.
// Define LCD_FAST_SIM_EN to collapse all timing units to one clock cycle.
module lcd_mensajes
  import lcd_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int MSG_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy
);

`ifdef LCD_FAST_SIM_EN
  localparam int US_CYC = 1;
  localparam int E_CYC  = 1;
`else
  localparam int US_CYC = CLK_HZ / 1_000_000;
  localparam int E_CYC  = (CLK_HZ / 4_000_000 > 0) ? CLK_HZ / 4_000_000 : 1;
`endif
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  lcd_state_e       st_q, st_d;
  logic [3:0]       step_q, step_d;
  logic             half_q, half_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       msg_q, msg_d, shown_q, shown_d;
  logic             shown_vld_q, shown_vld_d;
  logic             start, done;
  nib_req_t         req;
  logic [7:0]       cur_char, nxt_char, first_char;

  lcd_nibble_tx #(.US_CYC(US_CYC), .E_CYC(E_CYC)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .nib     (req.nib),
    .rs      (req.rs),
    .wait_us (req.wait_us),
    .lcd_d   (lcd_d),
    .lcd_rs  (lcd_rs),
    .lcd_e   (lcd_e),
    .done    (done)
  );

  assign lcd_rw = 1'b0;
  assign busy   = (st_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= S_PWR_WAIT;
      step_q      <= '0;
      half_q      <= 1'b0;
      idx_q       <= '0;
      msg_q       <= '0;
      shown_q     <= '0;
      shown_vld_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      step_q      <= step_d;
      half_q      <= half_d;
      idx_q       <= idx_d;
      msg_q       <= msg_d;
      shown_q     <= shown_d;
      shown_vld_q <= shown_vld_d;
    end
  end

  assign cur_char   = msg_char(msg_q, 8'(idx_q));
  assign nxt_char   = msg_char(msg_q, 8'(idx_q) + 8'd1);
  assign first_char = msg_char(msg_q, 8'd0);

  always_comb begin
    st_d        = st_q;
    step_d      = step_q;
    half_d      = half_q;
    idx_d       = idx_q;
    msg_d       = msg_q;
    shown_d     = shown_q;
    shown_vld_d = shown_vld_q;
    start       = 1'b0;
    req         = '0;
    case (st_q)
      S_PWR_WAIT: if (done) begin
        start  = 1'b1;
        req    = init_step(4'd0);
        step_d = 4'd0;
        st_d   = S_INIT;
      end
      S_INIT: if (done) begin
        if (step_q == 4'(INIT_STEPS - 1)) st_d = S_IDLE;
        else begin
          start  = 1'b1;
          req    = init_step(step_q + 4'd1);
          step_d = step_q + 4'd1;
        end
      end
      S_IDLE: if (!shown_vld_q || shown_q != code) begin
        start       = 1'b1;
        req         = '{nib: CMD_LINE1[7:4], rs: 1'b0, wait_us: NIB_GAP_US};
        msg_d       = code;
        shown_d     = code;
        shown_vld_d = 1'b1;
        half_d      = 1'b0;
        st_d        = S_ADDR;
      end
      S_ADDR: if (done) begin
        start = 1'b1;
        if (!half_q) begin
          req    = '{nib: CMD_LINE1[3:0], rs: 1'b0, wait_us: CMD_WAIT_US};
          half_d = 1'b1;
        end else begin
          req    = '{nib: first_char[7:4], rs: 1'b1, wait_us: NIB_GAP_US};
          idx_d  = '0;
          half_d = 1'b0;
          st_d   = S_CHARS;
        end
      end
      S_CHARS: if (done) begin
        if (!half_q) begin
          start  = 1'b1;
          req    = '{nib: cur_char[3:0], rs: 1'b1, wait_us: CMD_WAIT_US};
          half_d = 1'b1;
        end else if (idx_q == IDX_W'(MSG_LEN - 1)) begin
          idx_d  = '0;
          half_d = 1'b0;
          st_d   = S_IDLE;
        end else begin
          start  = 1'b1;
          req    = '{nib: nxt_char[7:4], rs: 1'b1, wait_us: NIB_GAP_US};
          idx_d  = idx_q + 1'b1;
          half_d = 1'b0;
        end
      end
      default: st_d = S_PWR_WAIT;
    endcase
  end

endmodule
